// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised VGA raster timing generator.
//
// Runs a horizontal/vertical counter pair (active, front porch, sync, back
// porch on both axes), presents the current position to a pixel source with
// a configurable read latency, and registers delay-matched colour and sync
// onto the VGA pins.
//
// Optional feature (compile-time macro VGA_TIMING_TESTPAT_EN):
//   When defined and test_mode=1, the colour mux ignores pix_data and shows
//   eight vertical colour bars derived from the delayed horizontal count.
//   When the macro is undefined, test_mode is ignored and no bar logic exists.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   en           pixel tick; everything advances only on clk edges with en=1
//   test_mode    colour-bar select (only with VGA_TIMING_TESTPAT_EN)
//   pix_data     pixel colour {b,g,r}, r in LSBs, valid PIX_LAT ticks after
//                its coordinates were presented
//   pix_x/pix_y  current raw horizontal/vertical count
//   pix_req      current position lies in the active area
//   line_start   en-qualified pulse at h==0
//   frame_start  en-qualified pulse at h==0, v==0
//   vga_r/g/b    registered colour, blanked outside the active area
//   vga_hs/vs    registered sync with configurable asserted level
// -----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 56,
    parameter int H_SYNC   = 120,
    parameter int H_BP     = 64,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 37,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 23,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int CW       = 11,
    parameter int COLOR_W  = 4,
    parameter int PIX_LAT  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 test_mode,
    input  logic [3*COLOR_W-1:0] pix_data,
    output logic [CW-1:0]        pix_x,
    output logic [CW-1:0]        pix_y,
    output logic                 pix_req,
    output logic                 line_start,
    output logic                 frame_start,
    output logic [COLOR_W-1:0]   vga_r,
    output logic [COLOR_W-1:0]   vga_g,
    output logic [COLOR_W-1:0]   vga_b,
    output logic                 vga_hs,
    output logic                 vga_vs
);

    // ------------------------------------------------------------------
    // Timing constants, all sized to the counter width so every compare
    // is an unsigned CW-bit compare.
    // ------------------------------------------------------------------
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] H_SYNC_S = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] H_SYNC_E = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] V_SYNC_S = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] V_SYNC_E = CW'(V_ACTIVE + V_FP + V_SYNC);

    // ------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------
    logic [CW-1:0] h;
    logic [CW-1:0] v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h <= '0;
            v <= '0;
        end else if (en) begin
            if (h == H_LAST) begin
                h <= '0;
                // vertical count moves only on the tick where the line wraps
                v <= (v == V_LAST) ? '0 : v + 1'b1;
            end else begin
                h <= h + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 0: decode of the current position
    // ------------------------------------------------------------------
    logic act_s0;
    logic hs_s0;
    logic vs_s0;

    assign act_s0 = (h < H_ACT_C) && (v < V_ACT_C);
    assign hs_s0  = (h >= H_SYNC_S) && (h < H_SYNC_E);
    assign vs_s0  = (v >= V_SYNC_S) && (v < V_SYNC_E);

    assign pix_x       = h;
    assign pix_y       = v;
    assign pix_req     = act_s0;
    assign line_start  = en && (h == '0);
    assign frame_start = en && (h == '0) && (v == '0);

    // ------------------------------------------------------------------
    // Delay pipeline: PIX_LAT en-gated stages so the blanking and sync
    // flags line up with the pixel source's data for the same position.
    // ------------------------------------------------------------------
    logic act_t;
    logic hs_t;
    logic vs_t;
`ifdef VGA_TIMING_TESTPAT_EN
    logic [CW-1:0] hx_t;
`endif

    generate
        if (PIX_LAT == 0) begin : g_nolat
            // combinational source: output registers sample stage 0 directly
            assign act_t = act_s0;
            assign hs_t  = hs_s0;
            assign vs_t  = vs_s0;
`ifdef VGA_TIMING_TESTPAT_EN
            assign hx_t  = h;
`endif
        end else begin : g_lat
            logic [PIX_LAT-1:0] act_pipe;
            logic [PIX_LAT-1:0] hs_pipe;
            logic [PIX_LAT-1:0] vs_pipe;
`ifdef VGA_TIMING_TESTPAT_EN
            logic [PIX_LAT-1:0][CW-1:0] hx_pipe;
`endif

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    act_pipe <= '0;
                    hs_pipe  <= '0;
                    vs_pipe  <= '0;
`ifdef VGA_TIMING_TESTPAT_EN
                    hx_pipe  <= '0;
`endif
                end else if (en) begin
                    act_pipe[0] <= act_s0;
                    hs_pipe[0]  <= hs_s0;
                    vs_pipe[0]  <= vs_s0;
`ifdef VGA_TIMING_TESTPAT_EN
                    hx_pipe[0]  <= h;
`endif
                    for (int i = 1; i < PIX_LAT; i++) begin
                        act_pipe[i] <= act_pipe[i-1];
                        hs_pipe[i]  <= hs_pipe[i-1];
                        vs_pipe[i]  <= vs_pipe[i-1];
`ifdef VGA_TIMING_TESTPAT_EN
                        hx_pipe[i]  <= hx_pipe[i-1];
`endif
                    end
                end
            end

            assign act_t = act_pipe[PIX_LAT-1];
            assign hs_t  = hs_pipe[PIX_LAT-1];
            assign vs_t  = vs_pipe[PIX_LAT-1];
`ifdef VGA_TIMING_TESTPAT_EN
            assign hx_t  = hx_pipe[PIX_LAT-1];
`endif
        end
    endgenerate

    // ------------------------------------------------------------------
    // Colour select and blanking
    // ------------------------------------------------------------------
    logic [COLOR_W-1:0] r_nxt;
    logic [COLOR_W-1:0] g_nxt;
    logic [COLOR_W-1:0] b_nxt;

`ifdef VGA_TIMING_TESTPAT_EN
    localparam logic [CW+2:0] H_ACT_W = (CW+3)'(H_ACTIVE);
    logic [2:0] bar_idx;

    // bar index = h*8/H_ACTIVE; only meaningful inside the active area,
    // where it is always below 8
    assign bar_idx = 3'({hx_t, 3'b000} / H_ACT_W);
`else
    logic unused_test_mode;
    assign unused_test_mode = test_mode;
`endif

    always_comb begin
        r_nxt = pix_data[COLOR_W-1:0];
        g_nxt = pix_data[2*COLOR_W-1:COLOR_W];
        b_nxt = pix_data[3*COLOR_W-1:2*COLOR_W];
`ifdef VGA_TIMING_TESTPAT_EN
        if (test_mode) begin
            r_nxt = {COLOR_W{bar_idx[0]}};
            g_nxt = {COLOR_W{bar_idx[1]}};
            b_nxt = {COLOR_W{bar_idx[2]}};
        end
`endif
        if (!act_t) begin
            r_nxt = '0;
            g_nxt = '0;
            b_nxt = '0;
        end
    end

    // ------------------------------------------------------------------
    // Output registers: one more en-tick after the pipeline tail, giving
    // PIX_LAT+1 ticks from counter position to pin.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_r  <= '0;
            vga_g  <= '0;
            vga_b  <= '0;
            vga_hs <= ~HS_POL;
            vga_vs <= ~VS_POL;
        end else if (en) begin
            vga_r  <= r_nxt;
            vga_g  <= g_nxt;
            vga_b  <= b_nxt;
            vga_hs <= hs_t ? HS_POL : ~HS_POL;
            vga_vs <= vs_t ? VS_POL : ~VS_POL;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Small raster (H 16/3/4/5, V 6/2/2/3), HS_POL=0, VS_POL=1, PIX_LAT=2.
// The reference model counts en-ticks since reset and derives every output
// from the tick index with plain division/modulo. The bench plays the pixel
// source: during tick n it drives the colour code of position n-PIX_LAT
// (garbage outside the active area, which must be blanked).
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

    localparam int HA = 16, HFP = 3, HSW = 4, HBP = 5;
    localparam int VA = 6,  VFP = 2, VSW = 2, VBP = 3;
    localparam int HT = HA + HFP + HSW + HBP;   // 28
    localparam int VT = VA + VFP + VSW + VBP;   // 13
    localparam int L  = 2;
    localparam bit HPOL = 1'b0;
    localparam bit VPOL = 1'b1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        test_mode;
    logic [11:0] pix_data;
    logic [10:0] pix_x;
    logic [10:0] pix_y;
    logic        pix_req;
    logic        line_start;
    logic        frame_start;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        vga_hs;
    logic        vga_vs;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_tick = 0;     // en edges since reset = index of current tick
    logic [11:0] e_rgb;
    logic        e_hs;
    logic        e_vs;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HS_POL(HPOL), .VS_POL(VPOL), .CW(11), .COLOR_W(4), .PIX_LAT(L)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .test_mode(test_mode),
        .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y), .pix_req(pix_req),
        .line_start(line_start), .frame_start(frame_start),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (tick %0d, t=%0t)",
                     name, act, exp, n_tick, $time);
        end
    endtask

    function automatic logic [11:0] code(input int h, input int v);
        return {4'(v), 8'(h)};
    endfunction

    function automatic bit is_act(input int p);
        return ((p % HT) < HA) && (((p / HT) % VT) < VA);
    endfunction

    // pin values after the en edge of tick n show position n-L
    function automatic void pins_at(input int p, output logic [11:0] rgb,
                                    output logic hs, output logic vs);
        int h, v;
        if (p < 0) begin
            rgb = 12'h0; hs = ~HPOL; vs = ~VPOL;
            return;
        end
        h   = p % HT;
        v   = (p / HT) % VT;
        rgb = is_act(p) ? code(h, v) : 12'h0;
        hs  = (h >= HA + HFP && h < HA + HFP + HSW) ? HPOL : ~HPOL;
        vs  = (v >= VA + VFP && v < VA + VFP + VSW) ? VPOL : ~VPOL;
    endfunction

    // model advance
    always @(posedge clk) begin
        if (rst_n && en) begin
            pins_at(n_tick - L, e_rgb, e_hs, e_vs);
            n_tick++;
        end
    end

    // per-cycle compare, away from the active edge
    always @(negedge clk) begin
        int h, v;
        h = n_tick % HT;
        v = (n_tick / HT) % VT;
        chk("pix_x", pix_x, h);
        chk("pix_y", pix_y, v);
        chk("pix_req", pix_req, (h < HA && v < VA) ? 1 : 0);
        chk("line_start", line_start, (en && h == 0) ? 1 : 0);
        chk("frame_start", frame_start, (en && h == 0 && v == 0) ? 1 : 0);
        chk("rgb", {vga_b, vga_g, vga_r}, e_rgb);
        chk("vga_hs", vga_hs, e_hs);
        chk("vga_vs", vga_vs, e_vs);
    end

    // pixel source + en for the tick that has just begun
    task automatic drive(input bit e);
        int p;
        p  = n_tick - L;
        en = e;
        test_mode = 1'($urandom);
        if (p >= 0 && is_act(p)) pix_data = code(p % HT, (p / HT) % VT);
        else                     pix_data = 12'($urandom);
    endtask

    task automatic step(input bit e);
        @(posedge clk);
        #1 drive(e);
        #1;
    endtask

    task automatic model_reset();
        n_tick = 0;
        e_rgb  = 12'h0;
        e_hs   = ~HPOL;
        e_vs   = ~VPOL;
    endtask

    // assert reset between edges and check the pins without any clock
    task automatic do_reset(input string tag);
        @(posedge clk);
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        chk({tag, "_rst_x"}, pix_x, 0);
        chk({tag, "_rst_y"}, pix_y, 0);
        chk({tag, "_rst_req"}, pix_req, 1);
        chk({tag, "_rst_rgb"}, {vga_b, vga_g, vga_r}, 0);
        chk({tag, "_rst_hs"}, vga_hs, 1);
        chk({tag, "_rst_vs"}, vga_vs, 0);
        repeat (2) step(1'($urandom));
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(1'b1);
        #1 chk({tag, "_rel_frame_start"}, frame_start, 1);
    endtask

    initial begin
        rst_n = 1'b1; en = 1'b0; test_mode = 1'b0; pix_data = 12'h0;
        model_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        drive(1'b1);
        #1;

        // hand-computed anchors, en held high, N = edges since release
        for (int N = 0; N <= 30; N++) begin
            if (N > 0) step(1'b1);
            case (N)
                0:  begin chk("lit_frame_start", frame_start, 1);
                          chk("lit_x0", pix_x, 0); end
                2:  chk("lit_r_pipe_empty", vga_r, 0);
                5:  begin chk("lit_r_pos2", vga_r, 2);
                          chk("lit_g_pos2", vga_g, 0); end
                19: begin chk("lit_r_blank_h16", vga_r, 0);
                          chk("lit_vs_idle", vga_vs, 0); end
                21: chk("lit_hs_pos18", vga_hs, 1);
                22: chk("lit_hs_pos19", vga_hs, 0);
                25: chk("lit_hs_pos22", vga_hs, 0);
                26: chk("lit_hs_pos23", vga_hs, 1);
                28: begin chk("lit_line_start", line_start, 1);
                          chk("lit_y1", pix_y, 1);
                          chk("lit_x_wrap", pix_x, 0); end
                default: ;
            endcase
        end

        // run into the active area of line 5, then reset mid-frame
        for (int i = 0; i < 400 && n_tick < 5 * HT + 10; i++) step(1'b1);
        chk("mid_frame_pos", pix_y, 5);
        do_reset("mid");

        // strict en alternation 1,0,1,0
        for (int i = 0; i < 800; i++) step(i[0] == 1'b0);

        // random en / test_mode with occasional resets
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 799) == 0) do_reset("rnd");
            else step($urandom_range(0, 3) != 0);
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
